// File: rtl/rs_dec_pkg.sv
// rtl/rs_dec_pkg.sv - shared constants and types for the RS decoder frame controller
package rs_dec_pkg;

    localparam int BEATS = 17;
    localparam int TAG_W = 4;
    localparam int ERR_W = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FEED = 1'b1
    } in_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [ERR_W-1:0] err_cnt;
        logic             fail;
    } st_rec_t;

endpackage

// File: rtl/rs_status_fifo.sv
// rtl/rs_status_fifo.sv - small circular status FIFO; push while full is taken only alongside a pop
module rs_status_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rs_dec_frame_ctrl.sv
// rtl/rs_dec_frame_ctrl.sv - frame admission, stage-occupancy tracking and status reporting for the RS decoder
module rs_dec_frame_ctrl #(
    parameter int BEATS    = rs_dec_pkg::BEATS,
    parameter int TAG_W    = rs_dec_pkg::TAG_W,
    parameter int ST_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             synd_valid_o,
    output logic             synd_start_o,
    output logic             synd_last_o,
    input  logic             synd_s_valid_i,
    input  logic             ribm_done_i,
    input  logic             chien_done_i,
    input  logic             exceed_i,
    input  logic             forney_vld_i,
    input  logic             forney_den_zero_i,
    output logic             forney_s3_rdy_o,
    output logic             st_valid_o,
    input  logic             st_ready_i,
    output logic [TAG_W-1:0] st_tag_o,
    output logic [4:0]       st_err_cnt_o,
    output logic             st_fail_o,
    output logic             proto_err_o
);
    import rs_dec_pkg::*;

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(ST_DEPTH + 1);
    localparam int SW = TAG_W + ERR_W + 1;

    in_state_e        state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [TAG_W-1:0] next_tag_q, next_tag_d;
    logic [TAG_W-1:0] syn_tag_q, syn_tag_d, ribm_tag_q, ribm_tag_d, ch_tag_q, ch_tag_d;
    logic             syn_q, syn_d, ribm_q, ribm_d, ch_q, ch_d;
    logic [ERR_W-1:0] err_q, err_d, err_upd;
    logic             fail_q, fail_d, fail_upd;
    logic             proto_q, proto_d;

    logic             admit, beat_acc, last_beat, fv, ch_req, sval_ok, rdone_ok;
    logic             push, pop, full, empty;
    logic [CW-1:0]    count;
    logic [SW-1:0]    wdata, rdata;

    rs_status_fifo #(.DEPTH(ST_DEPTH), .WIDTH(SW)) u_st_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A frame is admitted only if its status is guaranteed a FIFO slot once it drains.
    assign admit = !syn_q && !ribm_q &&
                   (({1'b0, count} + (CW+1)'(ch_q)) < (CW+1)'(ST_DEPTH));
    assign in_ready_o   = !rst_i && ((state_q == S_FEED) || admit);
    assign beat_acc     = in_valid_i && in_ready_o;
    assign last_beat    = (beat_q == BW'(BEATS - 1));
    assign synd_valid_o = beat_acc;
    assign synd_start_o = beat_acc && (beat_q == '0);
    assign synd_last_o  = beat_acc && last_beat;

    assign forney_s3_rdy_o = ch_q && !rst_i;
    assign fv       = forney_vld_i && forney_s3_rdy_o;
    assign err_upd  = (fv && (err_q != '1)) ? err_q + 1'b1 : err_q;
    assign fail_upd = fail_q || (fv && forney_den_zero_i) || (exceed_i && ch_q);

    assign st_valid_o = !empty && !rst_i;
    assign pop        = st_valid_o && st_ready_i;
    assign ch_req     = chien_done_i && ch_q;
    assign push       = ch_req && (!full || pop);
    assign wdata      = {ch_tag_q, err_upd, fail_upd};
    assign {st_tag_o, st_err_cnt_o, st_fail_o} = rdata;
    assign proto_err_o = proto_q;

    // Syndrome results are only legal after the last beat has been fed (FSM back in IDLE).
    assign sval_ok  = synd_s_valid_i && syn_q && (state_q == S_IDLE);
    assign rdone_ok = ribm_done_i && ribm_q && (!ch_q || push);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        next_tag_d = next_tag_q;
        syn_d      = syn_q;
        ribm_d     = ribm_q;
        ch_d       = ch_q;
        syn_tag_d  = syn_tag_q;
        ribm_tag_d = ribm_tag_q;
        ch_tag_d   = ch_tag_q;
        err_d      = err_upd;
        fail_d     = fail_upd;
        proto_d    = proto_q || (synd_s_valid_i && !sval_ok) || (ribm_done_i && !rdone_ok) ||
                     (chien_done_i && !ch_q) || (ch_req && full && !pop);

        if (beat_acc) begin
            if (last_beat) begin
                beat_d  = '0;
                state_d = S_IDLE;
            end else begin
                beat_d  = beat_q + 1'b1;
                state_d = S_FEED;
            end
            if (beat_q == '0) begin
                syn_d      = 1'b1;
                syn_tag_d  = next_tag_q;
                next_tag_d = next_tag_q + 1'b1;
            end
        end

        if (push) ch_d = 1'b0;
        if (rdone_ok) begin
            ch_d     = 1'b1;
            ch_tag_d = ribm_tag_q;
            ribm_d   = 1'b0;
            err_d    = '0;
            fail_d   = 1'b0;
        end
        if (sval_ok) begin
            ribm_d     = 1'b1;
            ribm_tag_d = syn_tag_q;
            syn_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            next_tag_q <= '0;
            syn_q      <= 1'b0;
            ribm_q     <= 1'b0;
            ch_q       <= 1'b0;
            syn_tag_q  <= '0;
            ribm_tag_q <= '0;
            ch_tag_q   <= '0;
            err_q      <= '0;
            fail_q     <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            next_tag_q <= next_tag_d;
            syn_q      <= syn_d;
            ribm_q     <= ribm_d;
            ch_q       <= ch_d;
            syn_tag_q  <= syn_tag_d;
            ribm_tag_q <= ribm_tag_d;
            ch_tag_q   <= ch_tag_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            proto_q    <= proto_d;
        end
    end

endmodule
